fetch_stage: RTL

//  Instruction-fetch stage of the RV32I pipeline. Owns the fetch PC and issues one

---
 rtl/fetch_stage.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the fetch PC, runs a single-outstanding imem
// handshake and registers {instr, pc, pc+4, valid} into the IF/ID boundary.

module adder #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum_c
);
    assign o_sum_c = i_a + i_b;
endmodule

module fetch_stage #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_d,
    input  logic            flush_d,
    input  logic            redirect_e,
    input  logic [XLEN-1:0] target_e,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic [31:0]     instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic            valid_d
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_KILL = 2'd3
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc_f;
    logic [31:0]     r_hold_instr;
    logic [31:0]     r_instr_d;
    logic [XLEN-1:0] r_pc_d;
    logic [XLEN-1:0] r_pc_plus4_d;
    logic            r_valid_d;

    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_target;
    logic            w_load;
    logic [31:0]     w_load_instr;

    adder #(.W(XLEN)) u_pc_adder (
        .i_a     (r_pc_f),
        .i_b     (XLEN'(4)),
        .o_sum_c (w_pc_plus4)
    );

    assign w_target = target_e & ~XLEN'(3);

    // An instruction reaches IF/ID straight from memory or from the hold buffer.
    always_comb begin
        w_load       = 1'b0;
        w_load_instr = imem_rsp_data;
        if (!redirect_e && !stall_d) begin
            if (r_state == S_WAIT && imem_rsp_valid) begin
                w_load = 1'b1;
            end else if (r_state == S_HOLD) begin
                w_load       = 1'b1;
                w_load_instr = r_hold_instr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_REQ;
            r_pc_f       <= RESET_PC;
            r_hold_instr <= NOP;
            r_instr_d    <= NOP;
            r_pc_d       <= '0;
            r_pc_plus4_d <= '0;
            r_valid_d    <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (redirect_e) begin
                        r_pc_f <= w_target;
                        // a request accepted alongside a redirect returns a stale word
                        if (imem_req_ready) r_state <= S_KILL;
                    end else if (imem_req_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect_e) begin
                        r_pc_f  <= w_target;
                        r_state <= imem_rsp_valid ? S_REQ : S_KILL;
                    end else if (imem_rsp_valid) begin
                        if (stall_d) begin
                            r_hold_instr <= imem_rsp_data;
                            r_state      <= S_HOLD;
                        end else begin
                            r_state <= S_REQ;
                        end
                    end
                end
                S_HOLD: begin
                    if (redirect_e) begin
                        r_pc_f  <= w_target;
                        r_state <= S_REQ;
                    end else if (!stall_d) begin
                        r_state <= S_REQ;
                    end
                end
                S_KILL: begin
                    if (redirect_e) r_pc_f <= w_target;
                    if (imem_rsp_valid) r_state <= S_REQ;
                end
                default: r_state <= S_REQ;
            endcase

            if (w_load) r_pc_f <= w_pc_plus4;

            // IF/ID boundary: flush beats stall beats load
            if (flush_d) begin
                r_valid_d <= 1'b0;
                r_instr_d <= NOP;
            end else if (!stall_d) begin
                if (w_load) begin
                    r_valid_d    <= 1'b1;
                    r_instr_d    <= w_load_instr;
                    r_pc_d       <= r_pc_f;
                    r_pc_plus4_d <= w_pc_plus4;
                end else begin
                    r_valid_d <= 1'b0;
                end
            end
        end
    end

    assign imem_req_valid = (r_state == S_REQ);
    assign imem_req_addr  = r_pc_f;
    assign instr_d        = r_instr_d;
    assign pc_d           = r_pc_d;
    assign pc_plus4_d     = r_pc_plus4_d;
    assign valid_d        = r_valid_d;

endmodule
